// File: rtl/trs_dl_loader.sv
// Loader from the hps_io download stream into trs80 RAM: parses /CMD records or passes raw images through.
// One-entry write buffer: a byte's write appears one cycle later, held until mem_ready; ioctl_wait stalls hps_io meanwhile.
module trs_dl_loader #(
  parameter int              ADDR_W    = 16,
  parameter logic [7:0]      CMD_INDEX = 8'd2,
  parameter logic [7:0]      RAW_INDEX = 8'd1,
  parameter logic [ADDR_W:0] RAW_BASE  = 17'h10000
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_index,
  input  logic [15:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              mem_wr,
  output logic [ADDR_W:0]   mem_addr,
  output logic [7:0]        mem_data,
  input  logic              mem_ready,
  output logic              loader_busy,
  output logic [ADDR_W-1:0] execute_addr,
  output logic              execute_enable,
  output logic              load_error
);

  typedef enum logic [3:0] {
    S_IDLE, S_TYPE, S_LEN1, S_ALO, S_AHI, S_DATA, S_LEN2, S_XLO,
    S_XHI, S_LENS, S_SKIP, S_ERR, S_DONE, S_RAW, S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic              dl_q, dl_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              exec_q, exec_d;
  logic              xfer_q, xfer_d;
  logic              is_cmd_q, is_cmd_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] xaddr_q, xaddr_d;
  logic              wr_vld_q, wr_vld_d;
  logic [ADDR_W:0]   waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;

  logic              req;
  logic [ADDR_W:0]   req_addr;
  logic [7:0]        len_m2;
  logic              full;

  assign full           = wr_vld_q & ~mem_ready;
  assign ioctl_wait     = full;
  assign mem_wr         = wr_vld_q;
  assign mem_addr       = waddr_q;
  assign mem_data       = wdata_q;
  assign loader_busy    = busy_q;
  assign execute_addr   = xaddr_q;
  assign execute_enable = exec_q;
  assign load_error     = err_q;

  always_comb begin
    state_d  = state_q;
    dl_d     = ioctl_download;
    busy_d   = busy_q;
    err_d    = err_q;
    exec_d   = 1'b0;
    xfer_d   = xfer_q;
    is_cmd_d = is_cmd_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    xaddr_d  = xaddr_q;
    wr_vld_d = full;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    req      = 1'b0;
    req_addr = '0;
    len_m2   = ioctl_dout - 8'd2;

    if (ioctl_wr) begin
      case (state_q)
        S_TYPE: begin
          case (ioctl_dout)
            8'h01:        state_d = S_LEN1;
            8'h02:        state_d = S_LEN2;
            8'h00, 8'hFF: begin
              err_d   = 1'b1;
              state_d = S_ERR;
            end
            default:      state_d = S_LENS;
          endcase
        end
        S_LEN1: begin
          // Length counts the two address bytes; the 8-bit wrap maps 0/1/2 to 254/255/256.
          cnt_d   = (len_m2 == 8'd0) ? 9'd256 : {1'b0, len_m2};
          state_d = S_ALO;
        end
        S_ALO: begin
          ptr_d[7:0] = ioctl_dout;
          state_d    = S_AHI;
        end
        S_AHI: begin
          ptr_d[15:8] = ioctl_dout;
          state_d     = S_DATA;
        end
        S_DATA: begin
          req      = 1'b1;
          req_addr = {1'b0, ptr_q};
          ptr_d    = ptr_q + ADDR_W'(1);
          cnt_d    = cnt_q - 9'd1;
          if (cnt_q == 9'd1) state_d = S_TYPE;
        end
        S_LEN2: state_d = S_XLO;
        S_XLO: begin
          xaddr_d[7:0] = ioctl_dout;
          state_d      = S_XHI;
        end
        S_XHI: begin
          xaddr_d[15:8] = ioctl_dout;
          xfer_d        = 1'b1;
          state_d       = S_DONE;
        end
        S_LENS: begin
          cnt_d   = (ioctl_dout == 8'd0) ? 9'd256 : {1'b0, ioctl_dout};
          state_d = S_SKIP;
        end
        S_SKIP: begin
          cnt_d = cnt_q - 9'd1;
          if (cnt_q == 9'd1) state_d = S_TYPE;
        end
        S_RAW: begin
          req      = 1'b1;
          req_addr = RAW_BASE + (ADDR_W+1)'(ioctl_addr);
        end
        default: ;
      endcase
    end

    // A strobe into a still-full buffer keeps the old entry and flags the load as bad.
    if (ioctl_wr && busy_q && full) begin
      err_d = 1'b1;
    end else if (req) begin
      wr_vld_d = 1'b1;
      waddr_d  = req_addr;
      wdata_d  = ioctl_dout;
    end

    if (state_q == S_IDLE) begin
      if (ioctl_download && !dl_q) begin
        if (ioctl_index == CMD_INDEX) begin
          busy_d   = 1'b1;
          err_d    = 1'b0;
          xfer_d   = 1'b0;
          is_cmd_d = 1'b1;
          state_d  = S_TYPE;
        end else if (ioctl_index == RAW_INDEX) begin
          busy_d   = 1'b1;
          err_d    = 1'b0;
          xfer_d   = 1'b0;
          is_cmd_d = 1'b0;
          state_d  = S_RAW;
        end
      end
    end else if (state_q == S_FIN) begin
      if (!wr_vld_q) begin
        busy_d  = 1'b0;
        exec_d  = is_cmd_q & xfer_q & ~err_q;
        state_d = S_IDLE;
      end
    end else if (!ioctl_download && dl_q) begin
      // Judged on the state after any byte arriving with the falling edge.
      if (is_cmd_q && state_d != S_TYPE && state_d != S_DONE) err_d = 1'b1;
      state_d = S_FIN;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      dl_q     <= 1'b1;  // a download still high when reset lifts must not restart
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      exec_q   <= 1'b0;
      xfer_q   <= 1'b0;
      is_cmd_q <= 1'b0;
      cnt_q    <= '0;
      ptr_q    <= '0;
      xaddr_q  <= '0;
      wr_vld_q <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      dl_q     <= dl_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      exec_q   <= exec_d;
      xfer_q   <= xfer_d;
      is_cmd_q <= is_cmd_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      xaddr_q  <= xaddr_d;
      wr_vld_q <= wr_vld_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_trs_dl_loader.sv
// Bench for trs_dl_loader: directed and random CMD/RAW downloads against a record-level stream model.
module tb_trs_dl_loader;

  typedef logic [7:0] bq_t [$];

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic [15:0] ioctl_addr = 16'd0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic        ioctl_wait;
  logic        mem_wr;
  logic [16:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_ready = 1'b0;
  logic        loader_busy;
  logic [15:0] execute_addr;
  logic        execute_enable;
  logic        load_error;

  int checks = 0;
  int errors = 0;
  int stall_cfg = 0;
  int stall_n = 0;
  int cur_stall = 0;
  int wait_cnt = 0;
  int pulse_cnt = 0;

  logic [16:0] cap_addr [$];
  logic [7:0]  cap_data [$];
  logic [16:0] exp_addr [$];
  logic [7:0]  exp_data [$];
  bit          exp_pulse, exp_err, exp_xfer;
  logic [15:0] exp_exec;

  trs_dl_loader dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .loader_busy(loader_busy), .execute_addr(execute_addr),
    .execute_enable(execute_enable), .load_error(load_error)
  );

  always #5 clk_sys = ~clk_sys;

  // RAM responder: stalls each write stall_cfg cycles, then accepts and records it.
  always @(negedge clk_sys) begin
    if (execute_enable) pulse_cnt++;
    if (mem_wr) begin
      if (stall_n < stall_cfg) begin
        mem_ready = 1'b0;
        stall_n++;
      end else begin
        mem_ready = 1'b1;
        cap_addr.push_back(mem_addr);
        cap_data.push_back(mem_data);
        stall_n = 0;
      end
    end else begin
      mem_ready = 1'b0;
      stall_n = 0;
    end
    #1;
    if (ioctl_wait) wait_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(negedge clk_sys);
    #2;
  endtask

  // Walks the stream record by record to derive the writes, the transfer and any error.
  task automatic model_cmd(input bq_t s);
    int i, n, nd;
    bit trunc;
    logic [15:0] a;
    exp_addr.delete(); exp_data.delete();
    exp_err = 0; exp_xfer = 0; trunc = 0; i = 0; n = s.size();
    while (i < n) begin
      if (s[i] == 8'h00 || s[i] == 8'hFF) begin exp_err = 1; break; end
      if (s[i] == 8'h02) begin
        if (i + 4 > n) begin trunc = 1; break; end
        exp_exec = {s[i+3], s[i+2]};
        exp_xfer = 1;
        break;
      end
      if (i + 2 > n) begin trunc = 1; break; end
      if (s[i] == 8'h01) begin
        nd = (int'(s[i+1]) + 254) % 256;
        if (nd == 0) nd = 256;
        if (i + 4 > n) begin trunc = 1; break; end
        a = {s[i+3], s[i+2]};
        for (int k = 0; k < nd; k++) begin
          if (i + 4 + k >= n) begin trunc = 1; break; end
          exp_addr.push_back({1'b0, a + 16'(k)});
          exp_data.push_back(s[i+4+k]);
        end
        if (trunc) break;
        i += 4 + nd;
      end else begin
        nd = (s[i+1] == 8'h00) ? 256 : int'(s[i+1]);
        if (i + 2 + nd > n) begin trunc = 1; break; end
        i += 2 + nd;
      end
    end
    exp_pulse = exp_xfer && !exp_err && !trunc;
    exp_err   = exp_err || trunc;
  endtask

  task automatic gen_rand(input int mode, output bq_t s);
    int nrec, nd;
    s = {};
    nrec = $urandom_range(1, 4);
    for (int r = 0; r < nrec; r++) begin
      if ($urandom_range(0, 2) != 0) begin
        nd = $urandom_range(1, 8);
        s.push_back(8'h01); s.push_back(8'(nd + 2));
        s.push_back(8'($urandom)); s.push_back(8'($urandom));
        for (int k = 0; k < nd; k++) s.push_back(8'($urandom));
      end else begin
        nd = $urandom_range(1, 5);
        s.push_back(8'($urandom_range(3, 254))); s.push_back(8'(nd));
        for (int k = 0; k < nd; k++) s.push_back(8'($urandom));
      end
    end
    case (mode)
      1: begin
        s.push_back(8'h02); s.push_back(8'($urandom));
        s.push_back(8'($urandom)); s.push_back(8'($urandom));
        repeat ($urandom_range(0, 3)) s.push_back(8'($urandom));
      end
      2: begin
        s.push_back(($urandom_range(0, 1) != 0) ? 8'h00 : 8'hFF);
        repeat (3) s.push_back(8'($urandom));
      end
      3: void'(s.pop_back());
      default: ;
    endcase
  endtask

  task automatic start_dl(input logic [7:0] idx, input int stall);
    cap_addr.delete(); cap_data.delete();
    wait_cnt = 0; pulse_cnt = 0; stall_cfg = stall; cur_stall = stall;
    ioctl_index = idx;
    ioctl_download = 1'b1;
    step(); step();
    chk("busy_start", 32'(loader_busy), 32'((idx == 8'd1) || (idx == 8'd2)));
    if (idx == 8'd1 || idx == 8'd2) chk("err_clear", 32'(load_error), 0);
  endtask

  task automatic send_bytes(input bq_t s, input bit fall_last);
    int g;
    for (int i = 0; i < s.size(); i++) begin
      g = 0;
      while (ioctl_wait === 1'b1 && g < 200) begin
        ioctl_wr = 1'b0;
        step();
        g++;
      end
      if (g >= 200) chk("wait_timeout", 32'(ioctl_wait), 0);
      ioctl_wr = 1'b1;
      ioctl_addr = 16'(i);
      ioctl_dout = s[i];
      if (fall_last && i == s.size() - 1) ioctl_download = 1'b0;
      step();
      ioctl_wr = 1'b0;
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  task automatic finish_dl(input bit already_fell);
    int g;
    if (!already_fell) begin
      step();
      ioctl_download = 1'b0;
    end
    g = 0;
    while (loader_busy === 1'b1 && g < 1000) begin
      step();
      g++;
    end
    chk("busy_drop", 32'(loader_busy), 0);
    repeat (3) step();
  endtask

  task automatic check_dl(input string tag);
    int e0;
    chk({tag, "_nwr"}, 32'(cap_addr.size()), 32'(exp_addr.size()));
    for (int k = 0; k < cap_addr.size() && k < exp_addr.size(); k++) begin
      e0 = errors;
      chk({tag, "_addr"}, 32'(cap_addr[k]), 32'(exp_addr[k]));
      chk({tag, "_data"}, 32'(cap_data[k]), 32'(exp_data[k]));
      if (errors != e0) break;
    end
    chk({tag, "_pulse"}, 32'(pulse_cnt), 32'(exp_pulse));
    chk({tag, "_err"}, 32'(load_error), 32'(exp_err));
    chk({tag, "_wait"}, 32'(wait_cnt), 32'(cur_stall * exp_addr.size()));
    if (exp_xfer) chk({tag, "_exec"}, 32'(execute_addr), 32'(exp_exec));
  endtask

  initial begin
    bq_t s;
    int st;

    repeat (3) step();
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_wait", 32'(ioctl_wait), 0);
    chk("rst_busy", 32'(loader_busy), 0);
    chk("rst_exec_en", 32'(execute_enable), 0);
    chk("rst_err", 32'(load_error), 0);
    chk("rst_exec_addr", 32'(execute_addr), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    reset_n = 1'b1;
    repeat (2) step();

    // Basic CMD load with the RAM always ready.
    s = '{8'h01, 8'h05, 8'h00, 8'h52, 8'hAA, 8'hBB, 8'hCC, 8'h02, 8'h02, 8'h00, 8'h52};
    model_cmd(s);
    start_dl(8'd2, 0); send_bytes(s, 1'b0); finish_dl(1'b0); check_dl("basic");
    chk("basic_exec_const", 32'(execute_addr), 32'h5200);
    chk("basic_last_wr", 32'(cap_addr.size() == 3 ? cap_addr[2] : 17'h0), 32'h05202);

    // Same stream with three stall cycles per write.
    start_dl(8'd2, 3); send_bytes(s, 1'b0); finish_dl(1'b0); check_dl("stall");
    chk("stall_wait_const", 32'(wait_cnt), 9);

    // 254-byte record from len 0, then 256-byte record from len 2 wrapping through FFFF.
    s = '{8'h01, 8'h00, 8'h00, 8'h60};
    for (int k = 0; k < 254; k++) s.push_back(8'($urandom));
    s.push_back(8'h01); s.push_back(8'h02); s.push_back(8'hFF); s.push_back(8'hFF);
    for (int k = 0; k < 256; k++) s.push_back(8'($urandom));
    model_cmd(s);
    start_dl(8'd2, 0); send_bytes(s, 1'b0); finish_dl(1'b0); check_dl("wrap");
    chk("wrap_count", 32'(cap_addr.size()), 510);
    if (cap_addr.size() == 510) begin
      chk("wrap_first", 32'(cap_addr[0]), 32'h06000);
      chk("wrap_253", 32'(cap_addr[253]), 32'h060FD);
      chk("wrap_ffff", 32'(cap_addr[254]), 32'h0FFFF);
      chk("wrap_0000", 32'(cap_addr[255]), 32'h00000);
      chk("wrap_last", 32'(cap_addr[509]), 32'h000FE);
    end

    // Skip record, data record, clean EOF without a transfer.
    s = '{8'h05, 8'h03, 8'h11, 8'h22, 8'h33, 8'h01, 8'h03, 8'h00, 8'h70, 8'h5A};
    model_cmd(s);
    start_dl(8'd2, 1); send_bytes(s, 1'b0); finish_dl(1'b0); check_dl("skip");

    // Other indices leave the loader idle.
    s = '{8'h01, 8'h03, 8'h00, 8'h70, 8'h5A};
    exp_addr.delete(); exp_data.delete();
    exp_pulse = 0; exp_err = 0; exp_xfer = 0;
    start_dl(8'd3, 0); send_bytes(s, 1'b0);
    chk("ign_busy", 32'(loader_busy), 0);
    finish_dl(1'b0); check_dl("ignored");

    // Raw pass-through at the base offset.
    s = {};
    exp_addr.delete(); exp_data.delete();
    for (int k = 0; k < 4; k++) begin
      s.push_back(8'($urandom));
      exp_addr.push_back(17'h10000 + 17'(k));
      exp_data.push_back(s[k]);
    end
    exp_pulse = 0; exp_err = 0; exp_xfer = 0;
    start_dl(8'd1, 2); send_bytes(s, 1'b0); finish_dl(1'b0); check_dl("raw");

    // Transfer record whose last byte coincides with the falling download.
    s = '{8'h02, 8'h00, 8'h34, 8'h12};
    model_cmd(s);
    start_dl(8'd2, 0); send_bytes(s, 1'b1); finish_dl(1'b1); check_dl("fall_wr");
    chk("fall_exec_const", 32'(execute_addr), 32'h1234);

    // Truncated data record.
    s = '{8'h01, 8'h05, 8'h00, 8'h52, 8'hAA};
    model_cmd(s);
    start_dl(8'd2, 0); send_bytes(s, 1'b0); finish_dl(1'b0); check_dl("trunc");
    chk("trunc_err_const", 32'(load_error), 1);

    // Bad record type: earlier writes stand, rest discarded.
    s = '{8'h01, 8'h03, 8'h00, 8'h40, 8'h11, 8'hFF, 8'h02, 8'h02, 8'h00, 8'h40};
    model_cmd(s);
    start_dl(8'd2, 0); send_bytes(s, 1'b0); finish_dl(1'b0); check_dl("badtype");

    for (int r = 0; r < 12; r++) begin
      gen_rand(r % 4, s);
      st = $urandom_range(0, 2);
      model_cmd(s);
      start_dl(8'd2, st); send_bytes(s, 1'b0); finish_dl(1'b0); check_dl("rnd");
    end

    // Reset during DATA with a write held by the RAM.
    s = '{8'h01, 8'h05, 8'h00, 8'h52, 8'hAA};
    start_dl(8'd2, 1000); send_bytes(s, 1'b0);
    step();
    chk("rstmid_pending", 32'(mem_wr), 1);
    reset_n = 1'b0;
    step();
    chk("rstmid_mem_wr", 32'(mem_wr), 0);
    chk("rstmid_busy", 32'(loader_busy), 0);
    reset_n = 1'b1;
    step(); step();
    chk("rstmid_norestart", 32'(loader_busy), 0);
    ioctl_download = 1'b0;
    repeat (6) step();
    chk("rstmid_pulse", 32'(pulse_cnt), 0);
    chk("rstmid_busy_end", 32'(loader_busy), 0);
    stall_cfg = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
